// File: rtl/multicycle_ctrl.sv
// Control FSM sequencing the shared multicycle RV64I datapath (fetch/decode/exec/mem/wb).
// CTRL_ILLEGAL_TRAP_EN: when defined, unsupported opcodes lock the FSM in TRAP; else they retire as NOPs.
module multicycle_ctrl #(
    parameter int RETIRE_W = 64
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [31:0]         i_instr,
    input  logic                i_mem_ready,
    input  logic                i_branch_taken,
    output logic                o_pc_write,
    output logic                o_pc_src,
    output logic                o_ir_write,
    output logic                o_mem_read,
    output logic                o_mem_write,
    output logic                o_mem_addr_sel,
    output logic                o_reg_write,
    output logic [1:0]          o_alu_src_a,
    output logic [1:0]          o_alu_src_b,
    output logic [1:0]          o_alu_op,
    output logic [1:0]          o_wb_sel,
    output logic                o_illegal,
    output logic [2:0]          o_state,
    output logic [RETIRE_W-1:0] o_instret
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
        S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_SB    = 7'b1100011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    state_t     state, state_nxt;
    logic [6:0] opcode;
    logic       legal;
    logic       retire;
    logic       unused_instr;

    assign opcode       = i_instr[6:0];
    assign unused_instr = ^i_instr[31:7];
    assign o_state      = state;

    always_comb begin
        case (opcode)
            OP_R, OP_IMM, OP_LD, OP_S, OP_SB,
            OP_JALR, OP_JAL, OP_LUI, OP_AUIPC: legal = 1'b1;
            default:                           legal = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        o_pc_write     = 1'b0;
        o_pc_src       = 1'b0;
        o_ir_write     = 1'b0;
        o_mem_read     = 1'b0;
        o_mem_write    = 1'b0;
        o_mem_addr_sel = 1'b0;
        o_reg_write    = 1'b0;
        o_alu_src_a    = 2'd0;
        o_alu_src_b    = 2'd0;
        o_alu_op       = 2'd0;
        o_wb_sel       = 2'd0;
        o_illegal      = 1'b0;
        case (state)
            S_IDLE: state_nxt = S_FETCH;
            S_FETCH: begin
                // PC+4 from the live ALU result lands together with the IR load
                o_mem_read  = 1'b1;
                o_alu_src_b = 2'd1;
                if (i_mem_ready) begin
                    o_ir_write = 1'b1;
                    o_pc_write = 1'b1;
                    state_nxt  = S_DECODE;
                end
            end
            S_DECODE: begin
                o_alu_src_a = 2'd1;
                o_alu_src_b = 2'd2;
`ifdef CTRL_ILLEGAL_TRAP_EN
                state_nxt   = legal ? S_EXEC : S_TRAP;
`else
                state_nxt   = legal ? S_EXEC : S_FETCH;
`endif
            end
            S_EXEC: begin
                state_nxt = S_WB;
                case (opcode)
                    OP_R:   begin o_alu_src_a = 2'd2; o_alu_op = 2'd1; end
                    OP_IMM: begin o_alu_src_a = 2'd2; o_alu_src_b = 2'd2; o_alu_op = 2'd1; end
                    OP_LD, OP_S: begin
                        o_alu_src_a = 2'd2;
                        o_alu_src_b = 2'd2;
                        state_nxt   = S_MEM;
                    end
                    OP_SB: begin
                        o_alu_src_a = 2'd2;
                        o_alu_op    = 2'd2;
                        o_pc_write  = i_branch_taken;
                        o_pc_src    = 1'b1;
                        state_nxt   = S_FETCH;
                    end
                    OP_JAL:   begin o_pc_write = 1'b1; o_pc_src = 1'b1; end
                    OP_JALR:  begin o_alu_src_a = 2'd2; o_alu_src_b = 2'd2; end
                    OP_AUIPC: begin o_alu_src_a = 2'd1; o_alu_src_b = 2'd2; end
                    default:  ;
                endcase
            end
            S_MEM: begin
                o_mem_addr_sel = 1'b1;
                if (opcode == OP_LD) o_mem_read  = 1'b1;
                else                 o_mem_write = 1'b1;
                if (i_mem_ready) state_nxt = (opcode == OP_LD) ? S_WB : S_FETCH;
            end
            S_WB: begin
                o_reg_write = 1'b1;
                state_nxt   = S_FETCH;
                case (opcode)
                    OP_LD:   o_wb_sel = 2'd1;
                    OP_JAL:  o_wb_sel = 2'd2;
                    OP_JALR: begin o_wb_sel = 2'd2; o_pc_write = 1'b1; o_pc_src = 1'b1; end
                    OP_LUI:  o_wb_sel = 2'd3;
                    default: o_wb_sel = 2'd0;
                endcase
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_TRAP: o_illegal = 1'b1;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    // Any arrival in FETCH other than from IDLE or a FETCH stall retires an instruction
    assign retire = (state_nxt == S_FETCH) &&
                    (state == S_DECODE || state == S_EXEC || state == S_MEM || state == S_WB);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)    o_instret <= '0;
        else if (retire) o_instret <= o_instret + RETIRE_W'(1);
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl; a 2-bit-counter twin checks instret wrap.
module tb_multicycle_ctrl;
    logic        i_clk, i_rst_n, i_mem_ready, i_branch_taken;
    logic [31:0] i_instr;
    logic        o_pc_write, o_pc_src, o_ir_write, o_mem_read, o_mem_write;
    logic        o_mem_addr_sel, o_reg_write, o_illegal;
    logic [1:0]  o_alu_src_a, o_alu_src_b, o_alu_op, o_wb_sel;
    logic [2:0]  o_state;
    logic [63:0] o_instret;
    logic        w_pw, w_ps, w_irw, w_mr, w_mw, w_mas, w_rw, w_ill;
    logic [1:0]  w_a, w_b, w_op, w_wb;
    logic [2:0]  w_state;
    logic [1:0]  w_instret;
    logic [18:0] sc;
    int          n_chk = 0;
    int          n_fail = 0;

    multicycle_ctrl dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_instr(i_instr), .i_mem_ready(i_mem_ready),
        .i_branch_taken(i_branch_taken), .o_pc_write(o_pc_write), .o_pc_src(o_pc_src),
        .o_ir_write(o_ir_write), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
        .o_mem_addr_sel(o_mem_addr_sel), .o_reg_write(o_reg_write), .o_alu_src_a(o_alu_src_a),
        .o_alu_src_b(o_alu_src_b), .o_alu_op(o_alu_op), .o_wb_sel(o_wb_sel),
        .o_illegal(o_illegal), .o_state(o_state), .o_instret(o_instret)
    );

    multicycle_ctrl #(.RETIRE_W(2)) dut_w (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_instr(i_instr), .i_mem_ready(i_mem_ready),
        .i_branch_taken(i_branch_taken), .o_pc_write(w_pw), .o_pc_src(w_ps),
        .o_ir_write(w_irw), .o_mem_read(w_mr), .o_mem_write(w_mw),
        .o_mem_addr_sel(w_mas), .o_reg_write(w_rw), .o_alu_src_a(w_a),
        .o_alu_src_b(w_b), .o_alu_op(w_op), .o_wb_sel(w_wb),
        .o_illegal(w_ill), .o_state(w_state), .o_instret(w_instret)
    );

    // {state, pc_write, pc_src, ir_write, mem_read, mem_write, mem_addr_sel, reg_write,
    //  alu_src_a, alu_src_b, alu_op, wb_sel, illegal}
    assign sc = {o_state, o_pc_write, o_pc_src, o_ir_write, o_mem_read, o_mem_write,
                 o_mem_addr_sel, o_reg_write, o_alu_src_a, o_alu_src_b, o_alu_op,
                 o_wb_sel, o_illegal};

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic test_reset();
        i_rst_n = 1'b0; i_mem_ready = 1'b1; i_branch_taken = 1'b0; i_instr = 32'h0;
        #12;
        n_chk++; if (sc !== {3'd0, 16'h0000}) begin n_fail++; $display("FAIL reset_outputs got %h exp %h", sc, {3'd0, 16'h0000}); end
        n_chk++; if (o_instret !== 64'd0) begin n_fail++; $display("FAIL reset_instret got %0d exp 0", o_instret); end
        @(negedge i_clk); i_rst_n = 1'b1;
        n_chk++; if (sc !== {3'd0, 16'h0000}) begin n_fail++; $display("FAIL reset_idle got %h exp %h", sc, {3'd0, 16'h0000}); end
    endtask

    task automatic test_addi();
        i_instr = 32'h00500093; i_mem_ready = 1'b1;
        @(negedge i_clk); n_chk++; if (sc !== {3'd1, 16'hB020}) begin n_fail++; $display("FAIL addi_fetch got %h exp %h", sc, {3'd1, 16'hB020}); end
        @(negedge i_clk); n_chk++; if (sc !== {3'd2, 16'h00C0}) begin n_fail++; $display("FAIL addi_decode got %h exp %h", sc, {3'd2, 16'h00C0}); end
        @(negedge i_clk); n_chk++; if (sc !== {3'd3, 16'h0148}) begin n_fail++; $display("FAIL addi_exec got %h exp %h", sc, {3'd3, 16'h0148}); end
        @(negedge i_clk); n_chk++; if (sc !== {3'd5, 16'h0200}) begin n_fail++; $display("FAIL addi_wb got %h exp %h", sc, {3'd5, 16'h0200}); end
        @(negedge i_clk); n_chk++; if (sc !== {3'd1, 16'hB020}) begin n_fail++; $display("FAIL addi_refetch got %h exp %h", sc, {3'd1, 16'hB020}); end
        n_chk++; if (o_instret !== 64'd1) begin n_fail++; $display("FAIL addi_instret got %0d exp 1", o_instret); end
    endtask

    task automatic test_load_wait();
        i_instr = 32'h0080B103;
        @(negedge i_clk); n_chk++; if (sc !== {3'd2, 16'h00C0}) begin n_fail++; $display("FAIL ld_decode got %h exp %h", sc, {3'd2, 16'h00C0}); end
        @(negedge i_clk); n_chk++; if (sc !== {3'd3, 16'h0140}) begin n_fail++; $display("FAIL ld_exec got %h exp %h", sc, {3'd3, 16'h0140}); end
        i_mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            if (k == 2) i_mem_ready = 1'b1;
            n_chk++; if (sc !== {3'd4, 16'h1400}) begin n_fail++; $display("FAIL ld_mem%0d got %h exp %h", k, sc, {3'd4, 16'h1400}); end
        end
        @(negedge i_clk); n_chk++; if (sc !== {3'd5, 16'h0202}) begin n_fail++; $display("FAIL ld_wb got %h exp %h", sc, {3'd5, 16'h0202}); end
        @(negedge i_clk); n_chk++; if (sc !== {3'd1, 16'hB020}) begin n_fail++; $display("FAIL ld_refetch got %h exp %h", sc, {3'd1, 16'hB020}); end
        n_chk++; if (o_instret !== 64'd2) begin n_fail++; $display("FAIL ld_instret got %0d exp 2", o_instret); end
    endtask

    task automatic test_store();
        i_instr = 32'h0020B823;
        @(negedge i_clk); n_chk++; if (sc !== {3'd2, 16'h00C0}) begin n_fail++; $display("FAIL sd_decode got %h exp %h", sc, {3'd2, 16'h00C0}); end
        @(negedge i_clk); n_chk++; if (sc !== {3'd3, 16'h0140}) begin n_fail++; $display("FAIL sd_exec got %h exp %h", sc, {3'd3, 16'h0140}); end
        @(negedge i_clk); n_chk++; if (sc !== {3'd4, 16'h0C00}) begin n_fail++; $display("FAIL sd_mem got %h exp %h", sc, {3'd4, 16'h0C00}); end
        @(negedge i_clk); n_chk++; if (sc !== {3'd1, 16'hB020}) begin n_fail++; $display("FAIL sd_refetch got %h exp %h", sc, {3'd1, 16'hB020}); end
        n_chk++; if (o_instret !== 64'd3) begin n_fail++; $display("FAIL sd_instret got %0d exp 3", o_instret); end
    endtask

    task automatic test_branch();
        i_instr = 32'h00000063; i_branch_taken = 1'b1;
        @(negedge i_clk); n_chk++; if (sc !== {3'd2, 16'h00C0}) begin n_fail++; $display("FAIL beq_t_decode got %h exp %h", sc, {3'd2, 16'h00C0}); end
        @(negedge i_clk); n_chk++; if (sc !== {3'd3, 16'hC110}) begin n_fail++; $display("FAIL beq_t_exec got %h exp %h", sc, {3'd3, 16'hC110}); end
        @(negedge i_clk); n_chk++; if (sc !== {3'd1, 16'hB020}) begin n_fail++; $display("FAIL beq_t_refetch got %h exp %h", sc, {3'd1, 16'hB020}); end
        i_branch_taken = 1'b0;
        @(negedge i_clk); @(negedge i_clk);
        n_chk++; if (sc !== {3'd3, 16'h4110}) begin n_fail++; $display("FAIL beq_nt_exec got %h exp %h", sc, {3'd3, 16'h4110}); end
        @(negedge i_clk); n_chk++; if (sc !== {3'd1, 16'hB020}) begin n_fail++; $display("FAIL beq_nt_refetch got %h exp %h", sc, {3'd1, 16'hB020}); end
        n_chk++; if (o_instret !== 64'd5) begin n_fail++; $display("FAIL beq_instret got %0d exp 5", o_instret); end
    endtask

    task automatic test_jal_lui();
        i_instr = 32'h0000006F;
        @(negedge i_clk); @(negedge i_clk);
        n_chk++; if (sc !== {3'd3, 16'hC000}) begin n_fail++; $display("FAIL jal_exec got %h exp %h", sc, {3'd3, 16'hC000}); end
        @(negedge i_clk); n_chk++; if (sc !== {3'd5, 16'h0204}) begin n_fail++; $display("FAIL jal_wb got %h exp %h", sc, {3'd5, 16'h0204}); end
        @(negedge i_clk); i_instr = 32'h000000B7;
        @(negedge i_clk); @(negedge i_clk);
        n_chk++; if (sc !== {3'd3, 16'h0000}) begin n_fail++; $display("FAIL lui_exec got %h exp %h", sc, {3'd3, 16'h0000}); end
        @(negedge i_clk); n_chk++; if (sc !== {3'd5, 16'h0206}) begin n_fail++; $display("FAIL lui_wb got %h exp %h", sc, {3'd5, 16'h0206}); end
        @(negedge i_clk); n_chk++; if (o_instret !== 64'd7) begin n_fail++; $display("FAIL lui_instret got %0d exp 7", o_instret); end
        n_chk++; if (w_instret !== 2'd3) begin n_fail++; $display("FAIL narrow_instret got %0d exp 3", w_instret); end
    endtask

    task automatic test_illegal();
        i_instr = 32'h0000007F;
        @(negedge i_clk); n_chk++; if (sc !== {3'd2, 16'h00C0}) begin n_fail++; $display("FAIL ill_decode got %h exp %h", sc, {3'd2, 16'h00C0}); end
`ifdef CTRL_ILLEGAL_TRAP_EN
        for (int k = 0; k < 10; k++) begin
            @(negedge i_clk);
            n_chk++; if (sc !== {3'd6, 16'h0001}) begin n_fail++; $display("FAIL ill_trap%0d got %h exp %h", k, sc, {3'd6, 16'h0001}); end
        end
`else
        @(negedge i_clk); n_chk++; if (sc !== {3'd1, 16'hB020}) begin n_fail++; $display("FAIL ill_nop_fetch got %h exp %h", sc, {3'd1, 16'hB020}); end
        n_chk++; if (o_instret !== 64'd8) begin n_fail++; $display("FAIL ill_nop_instret got %0d exp 8", o_instret); end
        n_chk++; if (w_instret !== 2'd0) begin n_fail++; $display("FAIL narrow_wrap got %0d exp 0", w_instret); end
`endif
    endtask

    task automatic test_reset_mid_ld();
        i_rst_n = 1'b0; #3; i_rst_n = 1'b1;
        i_instr = 32'h0020B823; i_mem_ready = 1'b1;
        repeat (5) @(negedge i_clk);
        n_chk++; if (sc !== {3'd1, 16'hB020} || o_instret !== 64'd1) begin n_fail++; $display("FAIL rst_pre got %h/%0d exp %h/1", sc, o_instret, {3'd1, 16'hB020}); end
        i_instr = 32'h0080B103;
        @(negedge i_clk); @(negedge i_clk); i_mem_ready = 1'b0;
        @(negedge i_clk); n_chk++; if (sc !== {3'd4, 16'h1400}) begin n_fail++; $display("FAIL rst_mem got %h exp %h", sc, {3'd4, 16'h1400}); end
        #1 i_rst_n = 1'b0;
        #1 n_chk++; if (sc !== {3'd0, 16'h0000}) begin n_fail++; $display("FAIL rst_async got %h exp %h", sc, {3'd0, 16'h0000}); end
        n_chk++; if (o_instret !== 64'd0) begin n_fail++; $display("FAIL rst_async_instret got %0d exp 0", o_instret); end
        i_mem_ready = 1'b1;
        @(posedge i_clk); #1;
        n_chk++; if (sc !== {3'd0, 16'h0000}) begin n_fail++; $display("FAIL rst_held got %h exp %h", sc, {3'd0, 16'h0000}); end
        @(negedge i_clk); i_rst_n = 1'b1;
        n_chk++; if (sc !== {3'd0, 16'h0000}) begin n_fail++; $display("FAIL rst_idle got %h exp %h", sc, {3'd0, 16'h0000}); end
        @(negedge i_clk); n_chk++; if (sc !== {3'd1, 16'hB020}) begin n_fail++; $display("FAIL rst_restart got %h exp %h", sc, {3'd1, 16'hB020}); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_wait();
        test_store();
        test_branch();
        test_jal_lui();
        test_illegal();
        test_reset_mid_ld();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
